// File: rtl/reorder_buffer.sv
// reorder_buffer
// In-order-commit reorder buffer: issue at tail, out-of-order writeback
// over WB_PORTS result channels, retire at head, registered redirect with
// full flush.
//
// Optional feature macro: ROB_BYPASS_EN
//   defined   : operand queries also forward same-cycle writebacks
//               (highest channel first), then stored state.
//   undefined : operand queries see stored state only.
//
// DEPTH_WIDTH must be at least 1; DEPTH = 2**DEPTH_WIDTH entries.

module reorder_buffer #(
    parameter int DEPTH_WIDTH = 3,
    parameter int WB_PORTS    = 2
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            rdy,
    // issue side
    input  logic                            instr_valid,
    input  logic [1:0]                      instr_kind,
    input  logic [4:0]                      instr_rd,
    input  logic                            instr_ready,
    input  logic [31:0]                     instr_value,
    output logic                            full,
    output logic                            empty,
    output logic [DEPTH_WIDTH-1:0]          issue_rob_id,
    // writeback side
    input  logic [WB_PORTS-1:0]             wb_valid,
    input  logic [WB_PORTS*DEPTH_WIDTH-1:0] wb_rob_id,
    input  logic [WB_PORTS*32-1:0]          wb_value,
    input  logic [WB_PORTS-1:0]             wb_redirect,
    input  logic [WB_PORTS*32-1:0]          wb_target,
    // commit side
    output logic                            commit_valid,
    output logic [DEPTH_WIDTH-1:0]          commit_rob_id,
    output logic [4:0]                      commit_rd,
    output logic [31:0]                     commit_value,
    output logic                            commit_store,
    // operand queries
    input  logic [DEPTH_WIDTH-1:0]          get_rob_id1,
    input  logic [DEPTH_WIDTH-1:0]          get_rob_id2,
    output logic                            get_ready1,
    output logic                            get_ready2,
    output logic [31:0]                     get_value1,
    output logic [31:0]                     get_value2,
    // redirect
    output logic                            clear,
    output logic [31:0]                     next_pc
);

    localparam int DEPTH = 1 << DEPTH_WIDTH;

    localparam logic [DEPTH_WIDTH:0]   CNT_FULL = (DEPTH_WIDTH+1)'(DEPTH);
    localparam logic [DEPTH_WIDTH:0]   CNT_ONE  = (DEPTH_WIDTH+1)'(1);
    localparam logic [DEPTH_WIDTH-1:0] ID_ONE   = DEPTH_WIDTH'(1);

    localparam logic [1:0] KIND_REG    = 2'd0;
    localparam logic [1:0] KIND_STORE  = 2'd1;
    localparam logic [1:0] KIND_BRANCH = 2'd2;

    // queue pointers and redirect state
    logic [DEPTH_WIDTH-1:0] r_head;
    logic [DEPTH_WIDTH-1:0] r_tail;
    logic [DEPTH_WIDTH:0]   r_count;
    logic                   r_clear;
    logic [31:0]            r_next_pc;

    // per-entry storage
    logic                   r_busy     [DEPTH];
    logic                   r_ready    [DEPTH];
    logic [1:0]             r_kind     [DEPTH];
    logic [4:0]             r_rd       [DEPTH];
    logic [31:0]            r_value    [DEPTH];
    logic                   r_redirect [DEPTH];
    logic [31:0]            r_target   [DEPTH];

    // unpacked views of the writeback channels
    logic [DEPTH_WIDTH-1:0] w_wb_id  [WB_PORTS];
    logic [31:0]            w_wb_val [WB_PORTS];
    logic [31:0]            w_wb_tgt [WB_PORTS];

    logic                   w_issue;
    logic                   w_commit;
    logic [1:0]             w_head_kind;

    for (genvar g = 0; g < WB_PORTS; g++) begin : g_wb_split
        assign w_wb_id[g]  = wb_rob_id[g*DEPTH_WIDTH +: DEPTH_WIDTH];
        assign w_wb_val[g] = wb_value[g*32 +: 32];
        assign w_wb_tgt[g] = wb_target[g*32 +: 32];
    end

    assign full         = (r_count == CNT_FULL);
    assign empty        = (r_count == '0);
    assign issue_rob_id = r_tail;

    // Issue is refused while full (judged on the current count, even if the
    // head retires this edge) and while a flush is pending.
    assign w_issue  = rdy && instr_valid && !full && !r_clear;
    assign w_commit = rdy && !r_clear && r_busy[r_head] && r_ready[r_head];

    assign w_head_kind   = r_kind[r_head];
    assign commit_valid  = w_commit;
    assign commit_rob_id = r_head;
    assign commit_rd     = (w_head_kind == KIND_STORE || w_head_kind == KIND_BRANCH)
                           ? 5'd0 : r_rd[r_head];
    assign commit_value  = r_value[r_head];
    assign commit_store  = w_commit && (w_head_kind == KIND_STORE);

    assign clear   = r_clear;
    assign next_pc = r_next_pc;

`ifdef ROB_BYPASS_EN
    // writebacks only land when the buffer is running and not flushing
    logic w_wb_live;
    assign w_wb_live = rdy && !r_clear;
`endif

    // Operand query 1: stored state, optionally overridden by a live writeback
    always_comb begin
        get_ready1 = r_busy[get_rob_id1] && r_ready[get_rob_id1];
        get_value1 = get_ready1 ? r_value[get_rob_id1] : 32'd0;
`ifdef ROB_BYPASS_EN
        for (int k = 0; k < WB_PORTS; k++) begin
            if (w_wb_live && wb_valid[k] && r_busy[get_rob_id1]
                && (w_wb_id[k] == get_rob_id1)) begin
                get_ready1 = 1'b1;
                get_value1 = w_wb_val[k];
            end
        end
`endif
    end

    // Operand query 2: same rules as query 1
    always_comb begin
        get_ready2 = r_busy[get_rob_id2] && r_ready[get_rob_id2];
        get_value2 = get_ready2 ? r_value[get_rob_id2] : 32'd0;
`ifdef ROB_BYPASS_EN
        for (int k = 0; k < WB_PORTS; k++) begin
            if (w_wb_live && wb_valid[k] && r_busy[get_rob_id2]
                && (w_wb_id[k] == get_rob_id2)) begin
                get_ready2 = 1'b1;
                get_value2 = w_wb_val[k];
            end
        end
`endif
    end

    // Queue control: reset, flush, writeback, issue, commit, occupancy
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_head    <= '0;
            r_tail    <= '0;
            r_count   <= '0;
            r_clear   <= 1'b0;
            r_next_pc <= 32'd0;
            for (int i = 0; i < DEPTH; i++) begin
                r_busy[i]  <= 1'b0;
                r_ready[i] <= 1'b0;
            end
        end else if (rdy) begin
            if (r_clear) begin
                // flush drops every in-flight entry; issue/writeback ignored
                r_head  <= '0;
                r_tail  <= '0;
                r_count <= '0;
                r_clear <= 1'b0;
                for (int i = 0; i < DEPTH; i++) begin
                    r_busy[i] <= 1'b0;
                end
            end else begin
                // ascending channel order: the highest channel's write lands last
                for (int k = 0; k < WB_PORTS; k++) begin
                    if (wb_valid[k] && r_busy[w_wb_id[k]]) begin
                        r_ready[w_wb_id[k]]    <= 1'b1;
                        r_value[w_wb_id[k]]    <= w_wb_val[k];
                        r_redirect[w_wb_id[k]] <= wb_redirect[k];
                        r_target[w_wb_id[k]]   <= w_wb_tgt[k];
                    end
                end

                // the tail slot is never busy when issue is accepted, so no
                // writeback can collide with the new entry
                if (w_issue) begin
                    r_busy[r_tail]     <= 1'b1;
                    r_ready[r_tail]    <= instr_ready;
                    r_kind[r_tail]     <= instr_kind;
                    r_rd[r_tail]       <= instr_rd;
                    r_value[r_tail]    <= instr_value;
                    r_redirect[r_tail] <= 1'b0;
                    r_tail             <= r_tail + ID_ONE;
                end

                if (w_commit) begin
                    r_busy[r_head] <= 1'b0;
                    r_head         <= r_head + ID_ONE;
                    if (r_redirect[r_head]) begin
                        r_clear   <= 1'b1;
                        r_next_pc <= r_target[r_head];
                    end
                end

                case ({w_issue, w_commit})
                    2'b10:   r_count <= r_count + CNT_ONE;
                    2'b01:   r_count <= r_count - CNT_ONE;
                    default: r_count <= r_count;
                endcase
            end
        end
    end

    // KIND_REG is the default encoding; kept named for readability of kind checks
    logic w_unused_kind;
    assign w_unused_kind = (KIND_REG == 2'd0);

endmodule

// File: tb/tb_reorder_buffer.sv
// Self-checking bench for reorder_buffer (DEPTH_WIDTH = 3, WB_PORTS = 2).
// A queue-based model tracks program order; a negedge process compares every
// output against it, and the directed sequence pins key values with literals.

module tb_reorder_buffer;

    localparam int DW    = 3;
    localparam int NP    = 2;
    localparam int DEPTH = 8;

    logic              clk = 1'b0;
    logic              rst;
    logic              rdy;
    logic              instr_valid;
    logic [1:0]        instr_kind;
    logic [4:0]        instr_rd;
    logic              instr_ready;
    logic [31:0]       instr_value;
    logic              full;
    logic              empty;
    logic [DW-1:0]     issue_rob_id;
    logic [NP-1:0]     wb_valid;
    logic [NP*DW-1:0]  wb_rob_id;
    logic [NP*32-1:0]  wb_value;
    logic [NP-1:0]     wb_redirect;
    logic [NP*32-1:0]  wb_target;
    logic              commit_valid;
    logic [DW-1:0]     commit_rob_id;
    logic [4:0]        commit_rd;
    logic [31:0]       commit_value;
    logic              commit_store;
    logic [DW-1:0]     get_rob_id1;
    logic [DW-1:0]     get_rob_id2;
    logic              get_ready1;
    logic              get_ready2;
    logic [31:0]       get_value1;
    logic [31:0]       get_value2;
    logic              clear;
    logic [31:0]       next_pc;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    reorder_buffer #(.DEPTH_WIDTH(DW), .WB_PORTS(NP)) dut (
        .clk(clk), .rst(rst), .rdy(rdy),
        .instr_valid(instr_valid), .instr_kind(instr_kind), .instr_rd(instr_rd),
        .instr_ready(instr_ready), .instr_value(instr_value),
        .full(full), .empty(empty), .issue_rob_id(issue_rob_id),
        .wb_valid(wb_valid), .wb_rob_id(wb_rob_id), .wb_value(wb_value),
        .wb_redirect(wb_redirect), .wb_target(wb_target),
        .commit_valid(commit_valid), .commit_rob_id(commit_rob_id),
        .commit_rd(commit_rd), .commit_value(commit_value), .commit_store(commit_store),
        .get_rob_id1(get_rob_id1), .get_rob_id2(get_rob_id2),
        .get_ready1(get_ready1), .get_ready2(get_ready2),
        .get_value1(get_value1), .get_value2(get_value2),
        .clear(clear), .next_pc(next_pc)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    int          mq[$];          // ids in program order, oldest first
    int          m_next;         // id the next issue receives
    bit          m_clear;
    logic [31:0] m_npc;
    bit          m_live = 0;
    bit          m_ready [DEPTH];
    logic [1:0]  m_kind  [DEPTH];
    logic [4:0]  m_rd    [DEPTH];
    logic [31:0] m_val   [DEPTH];
    bit          m_redir [DEPTH];
    logic [31:0] m_tgt   [DEPTH];

    function automatic bit in_q(input int id);
        foreach (mq[i]) if (mq[i] == id) return 1'b1;
        return 1'b0;
    endfunction

    function automatic int wb_id(input int k);
        return int'(wb_rob_id[k*DW +: DW]);
    endfunction

    function automatic void exp_query(input int id, output logic r, output logic [31:0] v);
        r = in_q(id) && m_ready[id];
        v = r ? m_val[id] : 32'd0;
`ifdef ROB_BYPASS_EN
        if (rdy && !m_clear && in_q(id)) begin
            for (int k = 0; k < NP; k++) begin
                if (wb_valid[k] && wb_id(k) == id) begin
                    r = 1'b1;
                    v = wb_value[k*32 +: 32];
                end
            end
        end
`endif
    endfunction

    always @(posedge clk) begin
        bit          c;
        bit          cr;
        logic [31:0] ct;
        int          id;
        c  = 1'b0;
        cr = 1'b0;
        ct = 32'd0;
        if (!rst) begin
            mq.delete();
            m_next  = 0;
            m_clear = 1'b0;
            m_npc   = 32'd0;
            m_live  = 1'b1;
            for (int i = 0; i < DEPTH; i++) m_ready[i] = 1'b0;
        end else if (m_live && rdy) begin
            if (m_clear) begin
                mq.delete();
                m_next  = 0;
                m_clear = 1'b0;
            end else begin
                if (mq.size() > 0 && m_ready[mq[0]]) begin
                    c  = 1'b1;
                    cr = m_redir[mq[0]];
                    ct = m_tgt[mq[0]];
                end
                for (int k = 0; k < NP; k++) begin
                    id = wb_id(k);
                    if (wb_valid[k] && in_q(id)) begin
                        m_ready[id] = 1'b1;
                        m_val[id]   = wb_value[k*32 +: 32];
                        m_redir[id] = wb_redirect[k];
                        m_tgt[id]   = wb_target[k*32 +: 32];
                    end
                end
                if (instr_valid && mq.size() < DEPTH) begin
                    m_ready[m_next] = instr_ready;
                    m_kind[m_next]  = instr_kind;
                    m_rd[m_next]    = instr_rd;
                    m_val[m_next]   = instr_value;
                    m_redir[m_next] = 1'b0;
                    mq.push_back(m_next);
                    m_next = (m_next + 1) % DEPTH;
                end
                if (c) begin
                    void'(mq.pop_front());
                    if (cr) begin
                        m_clear = 1'b1;
                        m_npc   = ct;
                    end
                end
            end
        end
    end

    // compare every output against the model mid-cycle
    always @(negedge clk) begin
        logic        ecv;
        logic        er;
        logic [31:0] ev;
        if (m_live && rst) begin
            ecv = rdy && !m_clear && mq.size() > 0 && m_ready[mq[0]];
            chk("m_full",  full,  mq.size() == DEPTH);
            chk("m_empty", empty, mq.size() == 0);
            chk("m_issue_id", issue_rob_id, m_next);
            chk("m_commit_valid", commit_valid, ecv);
            if (ecv) begin
                chk("m_commit_id", commit_rob_id, mq[0]);
                chk("m_commit_rd", commit_rd,
                    (m_kind[mq[0]] == 2'd1 || m_kind[mq[0]] == 2'd2) ? 5'd0 : m_rd[mq[0]]);
                chk("m_commit_value", commit_value, m_val[mq[0]]);
            end
            chk("m_commit_store", commit_store, ecv && m_kind[mq[0]] == 2'd1);
            chk("m_clear", clear, m_clear);
            if (m_clear) chk("m_next_pc", next_pc, m_npc);
            exp_query(int'(get_rob_id1), er, ev);
            chk("m_get_ready1", get_ready1, er);
            chk("m_get_value1", get_value1, ev);
            exp_query(int'(get_rob_id2), er, ev);
            chk("m_get_ready2", get_ready2, er);
            chk("m_get_value2", get_value2, ev);
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic step();
        @(posedge clk);
        #1;
        instr_valid = 1'b0;
        wb_valid    = '0;
        wb_redirect = '0;
    endtask

    task automatic issue(input logic [1:0] kind, input logic [4:0] rd,
                         input logic rdyv, input logic [31:0] val);
        instr_valid = 1'b1;
        instr_kind  = kind;
        instr_rd    = rd;
        instr_ready = rdyv;
        instr_value = val;
    endtask

    task automatic wb(input int k, input int id, input logic [31:0] val,
                      input logic redir, input logic [31:0] tgt);
        wb_valid[k]             = 1'b1;
        wb_rob_id[k*DW +: DW]   = DW'(id);
        wb_value[k*32 +: 32]    = val;
        wb_redirect[k]          = redir;
        wb_target[k*32 +: 32]   = tgt;
    endtask

    initial begin
        rst = 1'b0; rdy = 1'b1;
        instr_valid = 1'b0; instr_kind = 2'd0; instr_rd = 5'd0;
        instr_ready = 1'b0; instr_value = 32'd0;
        wb_valid = '0; wb_rob_id = '0; wb_value = '0; wb_redirect = '0; wb_target = '0;
        get_rob_id1 = '0; get_rob_id2 = '0;

        // reset
        step(); step();
        rst = 1'b1;
        #1;
        chk("rst_empty", empty, 1);
        chk("rst_full", full, 0);
        chk("rst_commit_valid", commit_valid, 0);
        chk("rst_clear", clear, 0);
        chk("rst_next_pc", next_pc, 0);
        chk("rst_issue_id", issue_rob_id, 0);
        chk("rst_get_ready1", get_ready1, 0);

        // fill to 8 entries, none ready
        for (int i = 0; i < DEPTH; i++) begin
            issue(2'd0, 5'(i + 1), 1'b0, 32'd0);
            step();
        end
        chk("fill_full", full, 1);
        chk("fill_issue_id", issue_rob_id, 0);
        issue(2'd0, 5'd20, 1'b1, 32'hDEAD);
        step();
        chk("ninth_full", full, 1);
        chk("ninth_issue_id", issue_rob_id, 0);

        // head becomes ready; issue while full and committing is still refused
        wb(0, 0, 32'h100, 1'b0, 32'd0);
        step();
        chk("fullc_commit_valid", commit_valid, 1);
        chk("fullc_full", full, 1);
        issue(2'd0, 5'd21, 1'b1, 32'hBEEF);
        step();
        chk("fullc_after_full", full, 0);
        chk("fullc_after_issue_id", issue_rob_id, 0);

        for (int i = 1; i < DEPTH; i += 2) begin
            wb(0, i, 32'h100 + i, 1'b0, 32'd0);
            if (i + 1 < DEPTH) wb(1, i + 1, 32'h100 + i + 1, 1'b0, 32'd0);
            step();
        end
        for (int n = 0; n < 40 && !empty; n++) step();
        chk("drain_empty", empty, 1);

        // out-of-order writeback, in-order commit
        issue(2'd0, 5'd5, 1'b0, 32'd0); step();
        issue(2'd0, 5'd6, 1'b0, 32'd0); step();
        chk("ooo_issue_id", issue_rob_id, 2);
        wb(0, 1, 32'h22, 1'b0, 32'd0); step();
        chk("ooo_no_commit", commit_valid, 0);
        wb(0, 0, 32'h11, 1'b0, 32'd0); step();
        chk("ooo_c0_valid", commit_valid, 1);
        chk("ooo_c0_id", commit_rob_id, 0);
        chk("ooo_c0_rd", commit_rd, 5);
        chk("ooo_c0_value", commit_value, 32'h11);
        step();
        chk("ooo_c1_valid", commit_valid, 1);
        chk("ooo_c1_id", commit_rob_id, 1);
        chk("ooo_c1_rd", commit_rd, 6);
        chk("ooo_c1_value", commit_value, 32'h22);
        step();
        chk("ooo_empty", empty, 1);

        // two channels hit id 2: channel 1 wins
        issue(2'd0, 5'd7, 1'b0, 32'd0); step();
        wb(0, 2, 32'hAA, 1'b0, 32'd0);
        wb(1, 2, 32'hBB, 1'b0, 32'd0);
        get_rob_id1 = 3'd2;
        step();
        chk("dual_get_value1", get_value1, 32'hBB);
        chk("dual_commit_value", commit_value, 32'hBB);
        step();
        chk("dual_empty", empty, 1);

        // branch redirect with younger entries in flight
        issue(2'd2, 5'd12, 1'b0, 32'd0); step();
        issue(2'd0, 5'd8, 1'b1, 32'h44); step();
        issue(2'd0, 5'd9, 1'b0, 32'd0); step();
        wb(1, 3, 32'd0, 1'b1, 32'h1000); step();
        chk("br_commit_valid", commit_valid, 1);
        chk("br_commit_id", commit_rob_id, 3);
        chk("br_commit_rd", commit_rd, 0);
        chk("br_clear_before", clear, 0);
        step();
        chk("br_clear", clear, 1);
        chk("br_next_pc", next_pc, 32'h1000);
        chk("br_clear_no_commit", commit_valid, 0);
        issue(2'd0, 5'd1, 1'b1, 32'h1);
        wb(0, 5, 32'h55, 1'b0, 32'd0);
        step();
        chk("br_after_clear", clear, 0);
        chk("br_after_empty", empty, 1);
        chk("br_after_issue_id", issue_rob_id, 0);

        // store commit
        issue(2'd1, 5'd9, 1'b1, 32'h77); step();
        chk("st_commit_valid", commit_valid, 1);
        chk("st_commit_store", commit_store, 1);
        chk("st_commit_rd", commit_rd, 0);
        step();
        chk("st_empty", empty, 1);

        // same-cycle query of a writeback
        issue(2'd0, 5'd3, 1'b0, 32'd0); step();
        get_rob_id1 = 3'd1;
        wb(0, 1, 32'h55, 1'b0, 32'd0);
        #1;
`ifdef ROB_BYPASS_EN
        chk("byp_ready_now", get_ready1, 1);
        chk("byp_value_now", get_value1, 32'h55);
`else
        chk("byp_ready_now", get_ready1, 0);
        chk("byp_value_now", get_value1, 0);
`endif
        step();
        chk("byp_ready_next", get_ready1, 1);
        chk("byp_value_next", get_value1, 32'h55);
        step();

        // rdy = 0 freezes everything
        issue(2'd0, 5'd4, 1'b1, 32'h66); step();
        rdy = 1'b0;
        issue(2'd0, 5'd2, 1'b1, 32'h67);
        #1;
        chk("frz_commit_valid", commit_valid, 0);
        step(); step();
        chk("frz_commit_valid2", commit_valid, 0);
        chk("frz_issue_id", issue_rob_id, 3);
        rdy = 1'b1;
        #1;
        chk("frz_resume_valid", commit_valid, 1);
        chk("frz_resume_value", commit_value, 32'h66);
        step();
        chk("frz_empty", empty, 1);

        // reset during a pending flush
        issue(2'd3, 5'd10, 1'b0, 32'd0); step();
        wb(0, 3, 32'h3004, 1'b1, 32'h2000); step();
        chk("jmp_commit_rd", commit_rd, 10);
        chk("jmp_commit_value", commit_value, 32'h3004);
        step();
        chk("jmp_clear", clear, 1);
        chk("jmp_next_pc", next_pc, 32'h2000);
        rst = 1'b0;
        step();
        rst = 1'b1;
        #1;
        chk("rflush_clear", clear, 0);
        chk("rflush_next_pc", next_pc, 0);
        chk("rflush_empty", empty, 1);
        chk("rflush_issue_id", issue_rob_id, 0);
        step(); step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
